// File: rtl/uart_tx_monitor.sv
// UART sink for uart0_tx: deserialises 8N1 frames, flags framing errors,
// collects characters into a line buffer and counts received bytes.
module uart_tx_monitor #(
  parameter int DIV      = 868,
  parameter int LINE_MAX = 64,
  parameter int LW       = $clog2(LINE_MAX + 1),
  parameter int AW       = $clog2(LINE_MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rxd,
  output logic [7:0]    byte_o,
  output logic          byte_vld_o,
  output logic          frame_err_o,
  output logic          line_done_o,
  output logic [LW-1:0] line_len_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  output logic [31:0]   rx_cnt_o
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] HALF_M1  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(DIV - 1);
  localparam logic [LW-1:0] PTR_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] PTR_ONE  = LW'(1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(LINE_MAX);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_r;
  logic [7:0]    shift_r;
  logic          sync1_r;
  logic          rxs_r;
  logic          prev_r;
  logic          fall_s;
  logic [LW-1:0] wr_ptr_r;
  logic          store_s;
  logic [7:0]    buf_r [LINE_MAX];

  // Two-flop synchroniser on rxd plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rxd;
      rxs_r   <= sync1_r;
      prev_r  <= rxs_r;
    end
  end

  assign fall_s  = ~rxs_r & prev_r;
  assign store_s = byte_vld_o && (byte_o != 8'h0D) && (byte_o != 8'h0A);

  // Frame FSM: samples each bit at its centre, cnt counts down to the next sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      bit_r       <= 3'd0;
      shift_r     <= 8'h00;
      byte_o      <= 8'h00;
      byte_vld_o  <= 1'b0;
      frame_err_o <= 1'b0;
      rx_cnt_o    <= 32'd0;
    end else begin
      byte_vld_o  <= 1'b0;
      frame_err_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fall_s) begin
            cnt_r   <= HALF_M1;
            state_r <= START;
          end
        end
        START: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else if (!rxs_r) begin
            cnt_r   <= FULL_M1;
            bit_r   <= 3'd0;
            state_r <= DATA;
          end else begin
            state_r <= IDLE;
          end
        end
        DATA: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            shift_r <= {rxs_r, shift_r[7:1]};
            cnt_r   <= FULL_M1;
            bit_r   <= bit_r + 3'd1;
            if (bit_r == 3'd7) begin
              state_r <= STOP;
            end
          end
        end
        STOP: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else if (rxs_r) begin
            byte_o     <= shift_r;
            byte_vld_o <= 1'b1;
            rx_cnt_o   <= rx_cnt_o + 32'd1;
            state_r    <= IDLE;
          end else begin
            frame_err_o <= 1'b1;
            state_r     <= WAIT_HI;
          end
        end
        // A stuck-low line (break) is absorbed here until it returns high
        WAIT_HI: begin
          if (rxs_r) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Line assembly: CR dropped, LF or a full buffer closes the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= PTR_ZERO;
      line_len_o  <= PTR_ZERO;
      line_done_o <= 1'b0;
    end else begin
      line_done_o <= 1'b0;
      if (byte_vld_o && (byte_o == 8'h0A)) begin
        line_len_o  <= wr_ptr_r;
        wr_ptr_r    <= PTR_ZERO;
        line_done_o <= 1'b1;
      end else if (store_s && ((wr_ptr_r + PTR_ONE) == LEN_MAX)) begin
        line_len_o  <= LEN_MAX;
        wr_ptr_r    <= PTR_ZERO;
        line_done_o <= 1'b1;
      end else if (store_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
    end
  end

  // Line buffer storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (store_s) begin
      buf_r[wr_ptr_r[AW-1:0]] <= byte_o;
    end
  end

  // Combinational buffer read, out-of-range addresses return zero
  always_comb begin
    rd_data_o = 8'h00;
    if (int'(rd_addr_i) < LINE_MAX) begin
      rd_data_o = buf_r[rd_addr_i];
    end else begin
      rd_data_o = 8'h00;
    end
  end
endmodule

// File: tb/tb_uart_tx_monitor.sv
// Self-checking bench for uart_tx_monitor: a table of frames with expected results,
// hand-written corner sequences and random frames against a byte/line-level model.
module tb_uart_tx_monitor;
  localparam int DIV = 16;
  localparam int LM  = 4;
  localparam int LW  = $clog2(LM + 1);
  localparam int AW  = $clog2(LM);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxd = 1'b1;
  logic [7:0]    byte_o;
  logic          byte_vld_o;
  logic          frame_err_o;
  logic          line_done_o;
  logic [LW-1:0] line_len_o;
  logic [AW-1:0] rd_addr_i = '0;
  logic [7:0]    rd_data_o;
  logic [31:0]   rx_cnt_o;

  uart_tx_monitor #(.DIV(DIV), .LINE_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd),
    .byte_o(byte_o), .byte_vld_o(byte_vld_o), .frame_err_o(frame_err_o),
    .line_done_o(line_done_o), .line_len_o(line_len_o),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rx_cnt_o(rx_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int vld_n = 0, err_n = 0, done_n = 0;
  int cyc = 0, vld_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters sampled on the inactive edge
  always @(negedge clk) begin
    if (byte_vld_o) begin
      vld_n   <= vld_n + 1;
      vld_cyc <= cyc;
    end
    if (frame_err_o) err_n <= err_n + 1;
    if (line_done_o) done_n <= done_n + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic apply(input logic [7:0] d, input logic stop, input int gap,
                       input int ev, input int ee, input int ed,
                       input logic [7:0] eb, input int el, input int ec);
    int v0, e0, d0;
    v0 = vld_n; e0 = err_n; d0 = done_n;
    send_frame(d, stop, gap);
    chk("byte_vld pulses", 32'(vld_n - v0), 32'(ev));
    chk("frame_err pulses", 32'(err_n - e0), 32'(ee));
    chk("line_done pulses", 32'(done_n - d0), 32'(ed));
    chk("byte_o", {24'd0, byte_o}, {24'd0, eb});
    chk("line_len_o", 32'(line_len_o), 32'(el));
    chk("rx_cnt_o", rx_cnt_o, 32'(ec));
  endtask

  task automatic chk_buf(input int a, input logic [7:0] e);
    rd_addr_i = AW'(a);
    #1;
    chk("rd_data_o", {24'd0, rd_data_o}, {24'd0, e});
  endtask

  task automatic chk_reset_vals();
    chk("reset byte_o", {24'd0, byte_o}, 32'd0);
    chk("reset byte_vld_o", {31'd0, byte_vld_o}, 32'd0);
    chk("reset frame_err_o", {31'd0, frame_err_o}, 32'd0);
    chk("reset line_done_o", {31'd0, line_done_o}, 32'd0);
    chk("reset line_len_o", 32'(line_len_o), 32'd0);
    chk("reset rx_cnt_o", rx_cnt_o, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         ev, ee, ed;
    logic [7:0] eb;
    int         el, ec;
    int         ra;
    logic [7:0] re;
  } vec_t;

  vec_t tbl[19];

  // Byte/line-level reference model state
  int         m_cnt, m_fill, m_len;
  logic [7:0] m_byte;
  logic [7:0] m_buf[LM];
  bit         m_ok[LM];

  initial begin
    int v0, e0, d0, c0, lat;
    // Frame stream with LINE_MAX=4: "OK\r\n", bad frame, "1\n", "ABCDE\n", "\n", "PQRS\n"
    tbl[0]  = '{8'h4F, 1'b1, 1, 0, 0, 8'h4F, 0,  1, 0, 8'h4F};
    tbl[1]  = '{8'h4B, 1'b1, 1, 0, 0, 8'h4B, 0,  2, 1, 8'h4B};
    tbl[2]  = '{8'h0D, 1'b1, 1, 0, 0, 8'h0D, 0,  3, 1, 8'h4B};
    tbl[3]  = '{8'h0A, 1'b1, 1, 0, 1, 8'h0A, 2,  4, 0, 8'h4F};
    tbl[4]  = '{8'hA5, 1'b0, 0, 1, 0, 8'h0A, 2,  4, 1, 8'h4B};
    tbl[5]  = '{8'h31, 1'b1, 1, 0, 0, 8'h31, 2,  5, 0, 8'h31};
    tbl[6]  = '{8'h0A, 1'b1, 1, 0, 1, 8'h0A, 1,  6, 0, 8'h31};
    tbl[7]  = '{8'h41, 1'b1, 1, 0, 0, 8'h41, 1,  7, 0, 8'h41};
    tbl[8]  = '{8'h42, 1'b1, 1, 0, 0, 8'h42, 1,  8, 1, 8'h42};
    tbl[9]  = '{8'h43, 1'b1, 1, 0, 0, 8'h43, 1,  9, 2, 8'h43};
    tbl[10] = '{8'h44, 1'b1, 1, 0, 1, 8'h44, 4, 10, 3, 8'h44};
    tbl[11] = '{8'h45, 1'b1, 1, 0, 0, 8'h45, 4, 11, 0, 8'h45};
    tbl[12] = '{8'h0A, 1'b1, 1, 0, 1, 8'h0A, 1, 12, 3, 8'h44};
    tbl[13] = '{8'h0A, 1'b1, 1, 0, 1, 8'h0A, 0, 13, 0, 8'h45};
    tbl[14] = '{8'h50, 1'b1, 1, 0, 0, 8'h50, 0, 14, 0, 8'h50};
    tbl[15] = '{8'h51, 1'b1, 1, 0, 0, 8'h51, 0, 15, 1, 8'h51};
    tbl[16] = '{8'h52, 1'b1, 1, 0, 0, 8'h52, 0, 16, 2, 8'h52};
    tbl[17] = '{8'h53, 1'b1, 1, 0, 1, 8'h53, 4, 17, 3, 8'h53};
    tbl[18] = '{8'h0A, 1'b1, 1, 0, 1, 8'h0A, 0, 18, 3, 8'h53};

    repeat (4) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame and its latency from the rxd falling edge
    c0 = cyc;
    apply(8'h55, 1'b1, 6, 1, 0, 0, 8'h55, 0, 1);
    lat = vld_cyc - c0;
    n_vec++;
    if (lat < 153 || lat > 157) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles expected 155+-2", lat);
    end

    do_reset();
    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].d, tbl[i].stop, 6, tbl[i].ev, tbl[i].ee, tbl[i].ed,
            tbl[i].eb, tbl[i].el, tbl[i].ec);
      chk_buf(tbl[i].ra, tbl[i].re);
    end

    // Bad stop bit followed by 40 extra low cycles, then a good frame
    do_reset();
    v0 = vld_n; e0 = err_n;
    send_frame(8'hA5, 1'b0, 0);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    chk("break frame_err pulses", 32'(err_n - e0), 32'd1);
    chk("break byte_vld pulses", 32'(vld_n - v0), 32'd0);
    apply(8'h31, 1'b1, 6, 1, 0, 0, 8'h31, 0, 1);

    // Short low glitch must be rejected as a false start
    v0 = vld_n; e0 = err_n; d0 = done_n;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch byte_vld pulses", 32'(vld_n - v0), 32'd0);
    chk("glitch frame_err pulses", 32'(err_n - e0), 32'd0);
    chk("glitch line_done pulses", 32'(done_n - d0), 32'd0);
    chk("glitch rx_cnt_o", rx_cnt_o, 32'd1);
    apply(8'h5A, 1'b1, 6, 1, 0, 0, 8'h5A, 0, 2);
    apply(8'h0A, 1'b1, 6, 1, 0, 1, 8'h0A, 2, 3);
    apply(8'h58, 1'b1, 6, 1, 0, 0, 8'h58, 2, 4);

    // Reset during data bit 3 discards the frame and the partial line
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = i[0];
      repeat (DIV) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    apply(8'h7E, 1'b1, 6, 1, 0, 0, 8'h7E, 0, 1);
    apply(8'h0A, 1'b1, 6, 1, 0, 1, 8'h0A, 1, 2);
    chk_buf(0, 8'h7E);

    // rxd held low across reset release ends in a framing error
    rst_n = 1'b0;
    rxd   = 1'b0;
    repeat (3) @(negedge clk);
    v0 = vld_n; e0 = err_n;
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("low-at-reset frame_err pulses", 32'(err_n - e0), 32'd1);
    chk("low-at-reset byte_vld pulses", 32'(vld_n - v0), 32'd0);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    apply(8'h21, 1'b1, 6, 1, 0, 0, 8'h21, 0, 1);

    // Random frames against the reference model
    do_reset();
    m_cnt = 0; m_fill = 0; m_len = 0; m_byte = 8'h00;
    for (int a = 0; a < LM; a++) m_ok[a] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       stop;
      int         r, ev, ee, ed;
      r = int'($urandom_range(0, 9));
      d = (r == 0) ? 8'h0A : (r == 1) ? 8'h0D : 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      ev = 0; ee = 0; ed = 0;
      if (stop) begin
        ev = 1;
        m_cnt++;
        m_byte = d;
        if (d == 8'h0A) begin
          ed = 1; m_len = m_fill; m_fill = 0;
        end else if (d != 8'h0D) begin
          m_buf[m_fill] = d;
          m_ok[m_fill]  = 1'b1;
          m_fill++;
          if (m_fill == LM) begin
            ed = 1; m_len = LM; m_fill = 0;
          end
        end
      end else begin
        ee = 1;
      end
      apply(d, stop, int'($urandom_range(3, 12)), ev, ee, ed, m_byte, m_len, m_cnt);
    end
    for (int a = 0; a < LM; a++) begin
      if (m_ok[a]) chk_buf(a, m_buf[a]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
